pipeline_stage_reg: RTL and testbench
=====================================

// Module: pipeline_stage_reg
// PURPOSE
// - Parametrised inter-stage register for the OTTER pipeline: decode->execute, execute->memory, memory->writeback.
// - Carries a control bundle (regWrite, memWrite, memRead2, alu_fun, rf_wr_sel, ...) and a data bundle (PC, rs1, rs2, immediates, ...).
// - Tracks a valid bit per stage. Supports hazard-unit stall (hold) and flush (bubble injection).
// - Optional depth >1 for retimed paths.
// PARAMETERS
// - CTRL_W   8   width of control bundle; all-zero = architectural NOP (no reg/mem write)
// - DATA_W   160 width of data bundle (default = PC + rs1 + rs2 + two immediates)
// - STAGES   1   register depth, legal 1..4; latency in cycles
// - CNT_W    16  perf counter width (used only with PIPE_REG_PERF_EN)
// PORTS
// - CLK        in  1       rising-edge clock
// - RST        in  1       synchronous, active-high reset
// - stall      in  1       hold all stages (hazard unit)
// - flush      in  1       kill all stages (branch/jump redirect)
// - valid_in   in  1       upstream stage holds a real instruction
// - ctrl_in    in  CTRL_W  control bundle from upstream
// - data_in    in  DATA_W  data bundle from upstream
// - valid_out  out 1       last stage holds a real instruction
// - ctrl_out   out CTRL_W  control bundle, forced 0 when valid_out=0
// - data_out   out DATA_W  data bundle of last stage
// - stall_cnt  out CNT_W   cycles with stall=1 and flush=0 (PIPE_REG_PERF_EN only)
// - flush_cnt  out CNT_W   cycles with flush=1 (PIPE_REG_PERF_EN only)
// BEHAVIOUR
// - One clock, CLK. RST is synchronous, active-high. All state updates on posedge CLK.
// - Each stage k (0..STAGES-1) holds {v[k], c[k], d[k]}. Stage 0 loads from the inputs; stage k loads from stage k-1.
// - Per-edge priority: RST > flush > stall > advance.
// - RST: all v=0, c=0, d=0. Outputs read 0 the cycle after the reset edge. Counters cleared.
// - flush=1: all v=0, c=0, d=0. Overrides a simultaneous stall. The input instruction is discarded.
// - stall=1 (flush=0): every stage holds its contents; inputs are ignored.
// - Advance: v[0]<=valid_in; c[0]<=valid_in ? ctrl_in : 0; d[0]<=data_in; higher stages shift by one.
// - Bubble rule: c[k]==0 whenever v[k]==0, so an invalid slot never writes the RF or memory.
// - Outputs are pure register outputs, no combinational input->output path:
//   valid_out=v[STAGES-1], ctrl_out=c[STAGES-1], data_out=d[STAGES-1].
// - Latency: exactly STAGES advancing edges from input to output. Stall cycles add latency one-for-one.
// - RST while stalled: reset wins and the pipe empties. The first edge after RST deasserts loads normally.
// - Illegal STAGES (<1 or >4) stops elaboration via $error.
// CONFIGURATION
// - Macro PIPE_REG_PERF_EN defined:
//   - stall_cnt and flush_cnt ports exist. Both cleared by RST.
//   - stall_cnt += 1 on each edge with stall=1 and flush=0.
//   - flush_cnt += 1 on each edge with flush=1.
//   - Both saturate at 2^CNT_W-1; no wrap.
// - Macro undefined: counter ports and logic are absent; all other behaviour is identical.
// TESTING
// - STAGES=1: valid_in=1, ctrl_in=8'hA5, data_in=X, one edge -> valid_out=1, ctrl_out=8'hA5, data_out=X.
// - STAGES=3: inject 3 instructions back to back -> each appears exactly 3 edges later, order preserved.
// - stall=1 for 4 cycles mid-stream -> outputs frozen, then resume. No instruction lost or duplicated.
// - valid_in=0 with ctrl_in=8'hFF -> valid_out=0, ctrl_out=0.
// - stall=1 and flush=1 on the same edge -> valid_out=0, ctrl_out=0. With PERF, flush_cnt=1 and stall_cnt=0.
// - RST asserted while stalled with a full pipe -> all outputs 0 next edge.
//   With PERF, CNT_W=4 and 20 stall cycles -> stall_cnt=15 (saturated).

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: parametrised inter-stage register for the OTTER pipeline.
// Carries a valid bit, a control bundle and a data bundle through STAGES
// register slots, with hazard-unit stall (hold) and flush (bubble injection).
// An invalid slot always carries an all-zero control bundle (architectural NOP).
//
// Optional feature: define PIPE_REG_PERF_EN to add saturating stall/flush
// performance counters (stall_cnt, flush_cnt ports).
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous, active-high reset
//   stall      hold all stages
//   flush      kill all stages (overrides stall)
//   valid_in   upstream holds a real instruction
//   ctrl_in    control bundle from upstream   [CTRL_W]
//   data_in    data bundle from upstream      [DATA_W]
//   valid_out  last stage holds a real instruction
//   ctrl_out   control bundle of last stage, zero when invalid
//   data_out   data bundle of last stage
//   stall_cnt  edges with stall=1 and flush=0 (PIPE_REG_PERF_EN only)
//   flush_cnt  edges with flush=1 (PIPE_REG_PERF_EN only)
module pipeline_stage_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 160,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
`ifdef PIPE_REG_PERF_EN
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`else
  output logic [DATA_W-1:0] data_out
`endif
);

  // Depth outside 1..4 is not supported.
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("pipeline_stage_reg: STAGES must be in 1..4");
  end

  logic              v_q [STAGES];
  logic [CTRL_W-1:0] c_q [STAGES];
  logic [DATA_W-1:0] d_q [STAGES];

  // Kill covers both reset and flush; they clear identically.
  logic kill_c;
  logic adv_c;

  assign kill_c = RST | flush;
  assign adv_c  = ~stall;

  // Stage 0 loads from the inputs; control is zeroed for a bubble.
  always_ff @(posedge CLK) begin
    if (kill_c) begin
      v_q[0] <= 1'b0;
      c_q[0] <= '0;
      d_q[0] <= '0;
    end else if (adv_c) begin
      v_q[0] <= valid_in;
      c_q[0] <= valid_in ? ctrl_in : '0;
      d_q[0] <= data_in;
    end
  end

  // Higher stages shift from the previous stage.
  for (genvar k = 1; k < STAGES; k++) begin : g_stage
    always_ff @(posedge CLK) begin
      if (kill_c) begin
        v_q[k] <= 1'b0;
        c_q[k] <= '0;
        d_q[k] <= '0;
      end else if (adv_c) begin
        v_q[k] <= v_q[k-1];
        c_q[k] <= c_q[k-1];
        d_q[k] <= d_q[k-1];
      end
    end
  end

  assign valid_out = v_q[STAGES-1];
  assign ctrl_out  = c_q[STAGES-1];
  assign data_out  = d_q[STAGES-1];

`ifdef PIPE_REG_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating event counters; flush takes precedence over stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (flush && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (stall && !flush && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Self-checking bench for pipeline_stage_reg: a 1-deep and a 3-deep instance
// share stimulus and are compared against a queue-based reference model.
module tb_pipeline_stage_reg;

  localparam int unsigned CW = 8;
  localparam int unsigned DW = 160;
  localparam int unsigned CNT1_W = 16;
  localparam int unsigned CNT3_W = 4;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          valid_in = 1'b0;
  logic [CW-1:0] ctrl_in = '0;
  logic [DW-1:0] data_in = '0;

  logic          v1, v3;
  logic [CW-1:0] c1, c3;
  logic [DW-1:0] d1, d3;
`ifdef PIPE_REG_PERF_EN
  logic [CNT1_W-1:0] sc1, fc1;
  logic [CNT3_W-1:0] sc3, fc3;
  int unsigned m_sc1, m_fc1, m_sc3, m_fc3;
`endif

  int checks = 0;
  int failures = 0;

  ent_t q1[$];
  ent_t q3[$];

  always #5 CLK = ~CLK;

  pipeline_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STAGES(1), .CNT_W(CNT1_W)) u1 (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .valid_out(v1), .ctrl_out(c1),
`ifdef PIPE_REG_PERF_EN
    .data_out(d1), .stall_cnt(sc1), .flush_cnt(fc1)
`else
    .data_out(d1)
`endif
  );

  pipeline_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STAGES(3), .CNT_W(CNT3_W)) u3 (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .valid_out(v3), .ctrl_out(c3),
`ifdef PIPE_REG_PERF_EN
    .data_out(d3), .stall_cnt(sc3), .flush_cnt(fc3)
`else
    .data_out(d3)
`endif
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned x, input int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 32'd1;
    return (x >= mx) ? mx : x + 1;
  endfunction

  // Pipe modelled as a fixed-length FIFO of instructions: each advance pushes
  // the incoming instruction and retires the oldest one to the output.
  task automatic model_reset_pipes();
    ent_t z;
    z = '0;
    q1.delete();
    q3.delete();
    q1.push_back(z);
    for (int i = 0; i < 3; i++) q3.push_back(z);
  endtask

  task automatic model_edge();
    ent_t e;
    if (RST || flush) begin
      model_reset_pipes();
    end else if (!stall) begin
      e.v = valid_in;
      e.c = valid_in ? ctrl_in : '0;
      e.d = data_in;
      q1.push_front(e);
      void'(q1.pop_back());
      q3.push_front(e);
      void'(q3.pop_back());
    end
`ifdef PIPE_REG_PERF_EN
    if (RST) begin
      m_sc1 = 0; m_fc1 = 0; m_sc3 = 0; m_fc3 = 0;
    end else begin
      if (flush) begin
        m_fc1 = sat_inc(m_fc1, CNT1_W);
        m_fc3 = sat_inc(m_fc3, CNT3_W);
      end else if (stall) begin
        m_sc1 = sat_inc(m_sc1, CNT1_W);
        m_sc3 = sat_inc(m_sc3, CNT3_W);
      end
    end
`endif
  endtask

  // One clock edge: update the model with the inputs seen at the edge,
  // then compare every output shortly after the edge.
  task automatic step(input string tag);
    ent_t e1, e3;
    @(posedge CLK);
    model_edge();
    #1;
    e1 = q1[$];
    e3 = q3[$];
    check({tag, ".v1"}, DW'(v1), DW'(e1.v));
    check({tag, ".c1"}, DW'(c1), DW'(e1.c));
    check({tag, ".d1"}, d1, e1.d);
    check({tag, ".v3"}, DW'(v3), DW'(e3.v));
    check({tag, ".c3"}, DW'(c3), DW'(e3.c));
    check({tag, ".d3"}, d3, e3.d);
`ifdef PIPE_REG_PERF_EN
    check({tag, ".sc1"}, DW'(sc1), DW'(m_sc1));
    check({tag, ".fc1"}, DW'(fc1), DW'(m_fc1));
    check({tag, ".sc3"}, DW'(sc3), DW'(m_sc3));
    check({tag, ".fc3"}, DW'(fc3), DW'(m_fc3));
`endif
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    valid_in = v;
    ctrl_in  = c;
    data_in  = d;
  endtask

  initial begin
    logic [DW-1:0] da, db, dc, dx;
    logic [CW-1:0] ca, cb, cc;
`ifdef PIPE_REG_PERF_EN
    m_sc1 = 0; m_fc1 = 0; m_sc3 = 0; m_fc3 = 0;
`endif
    model_reset_pipes();

    // Reset state.
    RST = 1'b1;
    drive(1'b1, 8'hFF, rand_data());
    step("reset0");
    step("reset1");
    RST = 1'b0;

    // Single-stage pass-through of one instruction.
    dx = rand_data();
    drive(1'b1, 8'hA5, dx);
    step("s1_load");
    check("s1_valid_const", DW'(v1), DW'(1'b1));
    check("s1_ctrl_const", DW'(c1), DW'(8'hA5));
    check("s1_data_const", d1, dx);

    // Three back-to-back instructions through the 3-deep pipe.
    da = rand_data(); db = rand_data(); dc = rand_data();
    ca = 8'h11; cb = 8'h22; cc = 8'h33;
    drive(1'b1, ca, da); step("b2b_a");
    drive(1'b1, cb, db); step("b2b_b");
    drive(1'b1, cc, dc); step("b2b_c");
    check("s3_first_ctrl", DW'(c3), DW'(ca));
    check("s3_first_data", d3, da);
    drive(1'b0, 8'h00, rand_data()); step("b2b_idle0");
    check("s3_second_ctrl", DW'(c3), DW'(cb));
    check("s3_second_data", d3, db);
    step("b2b_idle1");
    check("s3_third_ctrl", DW'(c3), DW'(cc));
    check("s3_third_data", d3, dc);
    step("b2b_idle2");
    check("s3_drained_valid", DW'(v3), DW'(1'b0));

    // Stream with a 4-cycle stall in the middle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, CW'($urandom_range(1, 255)), rand_data());
      step("stream_pre");
    end
    for (int i = 0; i < 4; i++) begin
      stall = 1'b1;
      drive(1'b1, CW'($urandom), rand_data());
      step("stream_stall");
    end
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, CW'($urandom_range(1, 255)), rand_data());
      step("stream_post");
    end

    // Invalid input with a non-zero control bundle becomes a bubble.
    drive(1'b0, 8'hFF, rand_data());
    step("bubble");
    check("bubble_valid_const", DW'(v1), DW'(1'b0));
    check("bubble_ctrl_const", DW'(c1), DW'(8'h00));

    // Stall and flush on the same edge, starting from cleared counters.
    RST = 1'b1; step("pre_flush_rst"); RST = 1'b0;
    drive(1'b1, 8'h5A, rand_data()); step("pre_flush_fill");
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 8'h77, rand_data());
    step("stall_flush");
    stall = 1'b0; flush = 1'b0;
    check("sf_valid1_const", DW'(v1), DW'(1'b0));
    check("sf_ctrl1_const", DW'(c1), DW'(8'h00));
    check("sf_valid3_const", DW'(v3), DW'(1'b0));
`ifdef PIPE_REG_PERF_EN
    check("sf_flush_cnt", DW'(fc3), DW'(4'd1));
    check("sf_stall_cnt", DW'(sc3), DW'(4'd0));
`endif

    // Reset while stalled with a full pipe.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, CW'($urandom_range(1, 255)), rand_data());
      step("full_fill");
    end
    stall = 1'b1; step("full_stall");
    RST = 1'b1; step("full_stall_rst");
    check("rst_stall_valid3", DW'(v3), DW'(1'b0));
    check("rst_stall_ctrl3", DW'(c3), DW'(8'h00));
    check("rst_stall_data3", d3, DW'(0));
    RST = 1'b0;

    // Long stall saturates the narrow counter.
    for (int i = 0; i < 20; i++) step("long_stall");
`ifdef PIPE_REG_PERF_EN
    check("stall_cnt_sat", DW'(sc3), DW'(4'd15));
    check("stall_cnt_wide", DW'(sc1), DW'(16'd20));
`endif
    stall = 1'b0;
    drive(1'b1, 8'h3C, rand_data());
    step("after_rst_load");

    // Randomised traffic with occasional stall, flush and reset.
    for (int i = 0; i < 400; i++) begin
      RST   = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 19) == 0);
      stall = ($urandom_range(0, 3) == 0);
      drive(1'($urandom_range(0, 1)), CW'($urandom), rand_data());
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
